store_queue_mp: RTL and testbench
=================================

# store_queue_mp

Parametrised, multi-port successor to the single-dispatch store queue in the LSU of the superscalar core.

- Accepts up to two executed stores per cycle from the LSU integer pipes, in program order.
- Marks entries committed from up to two ROB retire ports.
- Drains committed stores to the data memory through a valid/ready handshake.
- Squashes entries younger than a flush point.
- Forwards to loads at byte granularity, merging bytes from several older stores.

## Interface
Parameters
- SQ_DEPTH, 8: number of entries; power of two, at least 4.
- ROB_WIDTH, 5: ROB index width. robid is ROB_WIDTH+1 bits; the MSB is the wrap bit.
- CNT_W, $clog2(SQ_DEPTH+1): width of the free-count output.

Ports
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- enq_valid  in  2  per-lane enqueue request; lane 0 is older than lane 1.
- enq_robid  in  2×(ROB_WIDTH+1)  robid per lane.
- enq_addr / enq_data  in  2×32  byte address and unshifted store data per lane.
- enq_func3  in  2×3  F3_SB/F3_SH/F3_SW per lane.
- sq_free  out  CNT_W  free entries, registered.
- retire_valid  in  2  ROB retire strobes.
- retire_robid  in  2×(ROB_WIDTH+1)  robids being retired.
- flush_valid  in  1  squash request.
- flush_robid  in  ROB_WIDTH+1  robid of the oldest surviving instruction.
- mem_valid  out  1  head entry is committed and ready to write.
- mem_ready  in  1  memory accepts the write.
- mem_addr / mem_data  out  32  head entry address and data.
- mem_func3  out  3  head entry width code.
- ld_addr  in  32  load address for forwarding.
- ld_robid  in  ROB_WIDTH+1  robid of the load.
- fwd_data  out  32  merged forward data, byte-aligned to the word.
- fwd_mask  out  4  bytes supplied by fwd_data.

## Operation
- The queue is a circular buffer with head (oldest) and tail (next free) pointers of $clog2(SQ_DEPTH)+1 bits, including a wrap bit.
  - count = tail - head.
  - Full when count == SQ_DEPTH; empty when count == 0.
- Each entry holds: valid, committed, robid, addr, data, func3.
- Enqueue:
  - Active lanes are written to tail and tail+1 in lane order. If only lane 1 is valid, it goes to tail.
  - The LSU presents a lane only when sq_free covers it; an enqueue beyond free space is a protocol error and must be asserted in simulation.
- Retire: every valid, uncommitted entry whose robid equals an asserted retire_robid sets committed=1.
- Dequeue: mem_valid = head.valid & head.committed. On mem_valid & mem_ready, the head entry is cleared and head advances by one.
- Flush:
  - Younger(x, f) = (x[MSB] ^ f[MSB]) ^ (x[ROB_WIDTH-1:0] > f[ROB_WIDTH-1:0]).
  - Every valid, uncommitted entry with Younger(robid, flush_robid) is invalidated.
  - Tail is set to head + (number of surviving entries). Survivors are contiguous from head by program order.
- Forwarding (combinational): a candidate is any valid entry with addr[31:2] == ld_addr[31:2] and Younger(ld_robid, entry.robid).
  - For each byte b, fwd_data byte b and fwd_mask[b] come from the youngest candidate whose store covers b:
    - SB covers addr[1:0].
    - SH covers bytes {addr[1],0} and {addr[1],1}.
    - SW covers all four bytes.
  - Data is shifted to byte position, e.g. SB data[7:0] at addr[1:0]=2 goes to fwd_data[23:16].
  - fwd_mask = 0 when there is no candidate; fwd_data is then don't-care, driven 0.
- func3 values outside SB/SH/SW are treated as SW.

## Timing
- Reset (sync, reset_n low at posedge):
  - head = tail = 0; all valid and committed bits cleared.
  - sq_free = SQ_DEPTH, mem_valid = 0, fwd_mask = 0.
  - Reset mid-drain abandons in-flight state; no mem handshake is issued in the reset cycle.
- Enqueue latency: an entry is visible to forwarding and retire the cycle after enq_valid.
- Retire latency: mem_valid can rise the cycle after the retire strobe.
- Drain: one store per cycle maximum. mem_addr, mem_data and mem_func3 are stable while mem_valid & ~mem_ready.
- sq_free reflects enqueue, dequeue and flush of the previous edge.
- Simultaneous events:
  - Flush and enqueue in the same cycle: flush wins and enqueues are dropped.
  - Flush and dequeue: both take effect, and tail is computed against the new head.
  - Retire and dequeue of the same entry cannot occur, because committed must already be set.
  - Enqueue into a slot freed by the same-cycle dequeue is allowed only if sq_free (previous value) permitted it.
- Pointer wrap-around is transparent; full with both lanes valid is an error.

## Structure
- Package common already provides ROB_WIDTH and F3_SB/F3_SH/F3_SW. Add to it:
  - the sq_entry_t struct;
  - the function rob_younger(a, b).
- Sub-module sq_byte_fwd_picker: per-byte youngest-older match selection, ordered from head. Instantiated once, with the four byte lanes in a generate loop.

## Test plan
- Reset, then enqueue 2 SW/cycle × 4 cycles with SQ_DEPTH=8 -> sq_free goes 8,6,4,2,0; full; no mem_valid.
- Retire robid 3 and 4 (entries 0,1), mem_ready=1 -> mem_valid for 2 consecutive cycles with addr/data of entries 0 and 1 in order; head=2.
- Hold mem_ready=0 for 3 cycles with a committed head -> mem_* outputs stable; head unchanged until ready.
- Entries SW 0x1000=0xAABBCCDD (rob 1), then SB 0x1002=0x11 (rob 2); load 0x1000 with rob 5 -> fwd_mask=4'b1111, fwd_data=0xAA11CCDD. Load with rob 2 -> data 0xAABBCCDD.
- Six entries rob 10..15, entries 10,11 committed, flush_robid=12 with a same-cycle enqueue -> entries rob 13..15 cleared, enqueue dropped, sq_free=5.
- Robid wrap: entry rob {1,0x02}, flush_robid {0,0x1E} -> entry treated as younger and flushed; head/tail wrap past SQ_DEPTH with correct count.

Source files
------------

// File: rtl/store_queue_mp_pkg.sv
// Shared types and helpers for the multi-port store queue: ROB index width,
// store width codes, the queue entry layout and robid age comparison.
package store_queue_mp_pkg;

    localparam int ROB_WIDTH = 5;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic                 valid;
        logic                 committed;
        logic [ROB_WIDTH:0]   robid;
        logic [31:0]          addr;
        logic [31:0]          data;
        logic [2:0]           func3;
    } sq_entry_t;

    // True when robid a is younger than robid b; the MSB is the wrap bit.
    function automatic logic rob_younger(input logic [ROB_WIDTH:0] a,
                                         input logic [ROB_WIDTH:0] b);
        return (a[ROB_WIDTH] ^ b[ROB_WIDTH]) ^ (a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0]);
    endfunction

    // Bytes of the word written by a store; unknown width codes act as SW.
    function automatic logic [3:0] store_byte_mask(input logic [2:0] func3,
                                                   input logic [1:0] lo);
        case (func3)
            F3_SB:   store_byte_mask = 4'b0001 << lo;
            F3_SH:   store_byte_mask = lo[1] ? 4'b1100 : 4'b0011;
            F3_SW:   store_byte_mask = 4'b1111;
            default: store_byte_mask = 4'b1111;
        endcase
    endfunction

    // Replicates narrow store data across the word so every byte lane the
    // store covers already holds the right byte, whatever the offset.
    function automatic logic [31:0] store_lanes(input logic [2:0]  func3,
                                                input logic [31:0] data);
        case (func3)
            F3_SB:   store_lanes = {4{data[7:0]}};
            F3_SH:   store_lanes = {2{data[15:0]}};
            default: store_lanes = data;
        endcase
    endfunction

endpackage

// File: rtl/sq_byte_fwd_picker.sv
// Per-byte forwarding selection: for each byte lane, the youngest queue entry
// covering that byte wins. Entries are scanned oldest-first starting at head,
// so the last hit in the scan is the youngest.
module sq_byte_fwd_picker #(
    parameter int SQ_DEPTH = 8,
    parameter int IDX_W    = 3
) (
    input  logic [IDX_W-1:0]            head_i,
    input  logic [SQ_DEPTH-1:0][3:0]    cover_i,
    input  logic [SQ_DEPTH-1:0][31:0]   lanes_i,
    output logic [31:0]                 fwd_data_o,
    output logic [3:0]                  fwd_mask_o
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        logic [IDX_W-1:0] idx;
        logic [7:0]       byteData;
        logic             byteHit;

        // Walk entries in program order and keep the youngest covering store.
        always_comb begin
            byteHit  = 1'b0;
            byteData = 8'h00;
            idx      = head_i;
            for (int k = 0; k < SQ_DEPTH; k++) begin
                idx = head_i + IDX_W'(k);
                if (cover_i[idx][b]) begin
                    byteHit  = 1'b1;
                    byteData = lanes_i[idx][8*b +: 8];
                end
            end
        end

        assign fwd_data_o[8*b +: 8] = byteData;
        assign fwd_mask_o[b]        = byteHit;
    end

endmodule

// File: rtl/store_queue_mp.sv
// Two-lane store queue: in-order enqueue of executed stores, commit from two
// ROB retire ports, in-order drain to memory, squash on flush and byte-merged
// store-to-load forwarding.
module store_queue_mp #(
    parameter int SQ_DEPTH  = 8,
    parameter int ROB_WIDTH = store_queue_mp_pkg::ROB_WIDTH,
    parameter int CNT_W     = $clog2(SQ_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [1:0]                enq_valid_i,
    input  logic [1:0][ROB_WIDTH:0]   enq_robid_i,
    input  logic [1:0][31:0]          enq_addr_i,
    input  logic [1:0][31:0]          enq_data_i,
    input  logic [1:0][2:0]           enq_func3_i,
    output logic [CNT_W-1:0]          sq_free_o,
    input  logic [1:0]                retire_valid_i,
    input  logic [1:0][ROB_WIDTH:0]   retire_robid_i,
    input  logic                      flush_valid_i,
    input  logic [ROB_WIDTH:0]        flush_robid_i,
    output logic                      mem_valid_o,
    input  logic                      mem_ready_i,
    output logic [31:0]               mem_addr_o,
    output logic [31:0]               mem_data_o,
    output logic [2:0]                mem_func3_o,
    input  logic [31:0]               ld_addr_i,
    input  logic [ROB_WIDTH:0]        ld_robid_i,
    output logic [31:0]               fwd_data_o,
    output logic [3:0]                fwd_mask_o
);

    import store_queue_mp_pkg::*;

    localparam int IDX_W = $clog2(SQ_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    sq_entry_t                 entries_q [SQ_DEPTH];
    sq_entry_t                 entries_d [SQ_DEPTH];
    logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]          sq_free_q, sq_free_d;
    logic [PTR_W-1:0]          survivors, slot1;
    logic [1:0]                enq_cnt;
    logic [IDX_W-1:0]          head_idx;
    logic                      deq;
    logic [SQ_DEPTH-1:0][3:0]  fwd_cover;
    logic [SQ_DEPTH-1:0][31:0] fwd_lanes;
    logic [1:0]                ld_addr_lo_unused;

    // Forwarding matches whole words; the load's byte offset plays no part.
    assign ld_addr_lo_unused = ld_addr_i[1:0];

    assign head_idx = head_q[IDX_W-1:0];
    assign enq_cnt  = {1'b0, enq_valid_i[0]} + {1'b0, enq_valid_i[1]};

    // Gated by reset_n so no write handshake can complete in a reset cycle.
    assign mem_valid_o = reset_n & entries_q[head_idx].valid & entries_q[head_idx].committed;
    assign mem_addr_o  = entries_q[head_idx].addr;
    assign mem_data_o  = entries_q[head_idx].data;
    assign mem_func3_o = entries_q[head_idx].func3;
    assign deq         = mem_valid_o & mem_ready_i;
    assign sq_free_o   = sq_free_q;

    // Next queue state: retire, then dequeue, then either flush or enqueue.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        survivors = '0;
        slot1     = tail_q + PTR_W'(enq_valid_i[0]);

        for (int i = 0; i < SQ_DEPTH; i++) begin
            if (entries_q[i].valid && !entries_q[i].committed &&
                ((retire_valid_i[0] && entries_q[i].robid == retire_robid_i[0]) ||
                 (retire_valid_i[1] && entries_q[i].robid == retire_robid_i[1]))) begin
                entries_d[i].committed = 1'b1;
            end
        end

        if (deq) begin
            entries_d[head_idx].valid     = 1'b0;
            entries_d[head_idx].committed = 1'b0;
            head_d                        = head_q + PTR_W'(1);
        end

        if (flush_valid_i) begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                if (entries_d[i].valid && !entries_d[i].committed &&
                    rob_younger(entries_d[i].robid, flush_robid_i)) begin
                    entries_d[i].valid = 1'b0;
                end
            end
            for (int i = 0; i < SQ_DEPTH; i++) begin
                survivors = survivors + PTR_W'(entries_d[i].valid);
            end
            tail_d = head_d + survivors;
        end else begin
            if (enq_valid_i[0]) begin
                entries_d[tail_q[IDX_W-1:0]] = '{valid: 1'b1, committed: 1'b0,
                                                 robid: enq_robid_i[0], addr: enq_addr_i[0],
                                                 data: enq_data_i[0], func3: enq_func3_i[0]};
            end
            if (enq_valid_i[1]) begin
                entries_d[slot1[IDX_W-1:0]] = '{valid: 1'b1, committed: 1'b0,
                                                robid: enq_robid_i[1], addr: enq_addr_i[1],
                                                data: enq_data_i[1], func3: enq_func3_i[1]};
            end
            tail_d = tail_q + PTR_W'(enq_cnt);
        end

        sq_free_d = CNT_W'(SQ_DEPTH) - CNT_W'(tail_d - head_d);
    end

    // Queue state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            sq_free_q <= CNT_W'(SQ_DEPTH);
            for (int i = 0; i < SQ_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            sq_free_q <= sq_free_d;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    // Per-entry forwarding candidates: same word, and older than the load.
    always_comb begin
        fwd_cover = '0;
        fwd_lanes = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            if (entries_q[i].valid && entries_q[i].addr[31:2] == ld_addr_i[31:2] &&
                rob_younger(ld_robid_i, entries_q[i].robid)) begin
                fwd_cover[i] = store_byte_mask(entries_q[i].func3, entries_q[i].addr[1:0]);
            end
            fwd_lanes[i] = store_lanes(entries_q[i].func3, entries_q[i].data);
        end
    end

    sq_byte_fwd_picker #(
        .SQ_DEPTH (SQ_DEPTH),
        .IDX_W    (IDX_W)
    ) u_picker (
        .head_i     (head_idx),
        .cover_i    (fwd_cover),
        .lanes_i    (fwd_lanes),
        .fwd_data_o (fwd_data_o),
        .fwd_mask_o (fwd_mask_o)
    );

    // The LSU must never present more stores than there are free entries.
    assert property (@(posedge clk) disable iff (!reset_n)
                     !flush_valid_i |-> (CNT_W'(enq_cnt) <= sq_free_q))
        else $error("store_queue_mp: enqueue beyond free space");

endmodule

// File: tb/tb_store_queue_mp.sv
// Directed bench for store_queue_mp: fill/full, commit and drain, drain
// back-pressure, byte-merged forwarding, flush with dropped enqueue,
// flush with dequeue, and robid plus pointer wrap-around.
module tb_store_queue_mp;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       enqValid;
    logic [1:0][5:0]  enqRobid;
    logic [1:0][31:0] enqAddr;
    logic [1:0][31:0] enqData;
    logic [1:0][2:0]  enqFunc3;
    logic [3:0]       sqFree;
    logic [1:0]       retireValid;
    logic [1:0][5:0]  retireRobid;
    logic             flushValid;
    logic [5:0]       flushRobid;
    logic             memValid;
    logic             memReady;
    logic [31:0]      memAddr;
    logic [31:0]      memData;
    logic [2:0]       memFunc3;
    logic [31:0]      ldAddr;
    logic [5:0]       ldRobid;
    logic [31:0]      fwdData;
    logic [3:0]       fwdMask;

    int totalChecks = 0;
    int badChecks   = 0;

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    store_queue_mp dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enq_valid_i    (enqValid),
        .enq_robid_i    (enqRobid),
        .enq_addr_i     (enqAddr),
        .enq_data_i     (enqData),
        .enq_func3_i    (enqFunc3),
        .sq_free_o      (sqFree),
        .retire_valid_i (retireValid),
        .retire_robid_i (retireRobid),
        .flush_valid_i  (flushValid),
        .flush_robid_i  (flushRobid),
        .mem_valid_o    (memValid),
        .mem_ready_i    (memReady),
        .mem_addr_o     (memAddr),
        .mem_data_o     (memData),
        .mem_func3_o    (memFunc3),
        .ld_addr_i      (ldAddr),
        .ld_robid_i     (ldRobid),
        .fwd_data_o     (fwdData),
        .fwd_mask_o     (fwdMask)
    );

    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One clock edge, then drop the single-cycle strobes.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        enqValid    = 2'b00;
        retireValid = 2'b00;
        flushValid  = 1'b0;
    endtask

    task automatic enqLane(input int lane, input logic [5:0] robid, input logic [31:0] addr,
                           input logic [31:0] data, input logic [2:0] f3);
        enqValid[lane] = 1'b1;
        enqRobid[lane] = robid;
        enqAddr[lane]  = addr;
        enqData[lane]  = data;
        enqFunc3[lane] = f3;
    endtask

    task automatic retireLane(input int lane, input logic [5:0] robid);
        retireValid[lane] = 1'b1;
        retireRobid[lane] = robid;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus();
        applyStimulus();
        reset_n = 1'b1;
    endtask

    task automatic checkFwd(input string tag, input logic [31:0] addr, input logic [5:0] robid,
                            input logic [3:0] expMask, input logic [31:0] expData);
        ldAddr  = addr;
        ldRobid = robid;
        #1;
        checkOutput({tag, "_mask"}, 32'(fwdMask), 32'(expMask));
        checkOutput({tag, "_data"}, fwdData, expData);
    endtask

    initial begin
        enqValid    = '0;
        enqRobid    = '0;
        enqAddr     = '0;
        enqData     = '0;
        enqFunc3    = '0;
        retireValid = '0;
        retireRobid = '0;
        flushValid  = 1'b0;
        flushRobid  = '0;
        memReady    = 1'b0;
        ldAddr      = '0;
        ldRobid     = '0;

        // ---------------- reset, fill to full, commit and drain ----------------
        doReset();
        checkOutput("rst_free", 32'(sqFree), 32'd8);
        checkOutput("rst_mvalid", 32'(memValid), 32'd0);
        checkFwd("rst_fwd", 32'h0, 6'h3F, 4'h0, 32'h0);

        for (int k = 0; k < 4; k++) begin
            enqLane(0, 6'(3 + 2*k), 32'h100 + 32'(8*k), 32'hD000_0000 + 32'(2*k), SW);
            enqLane(1, 6'(4 + 2*k), 32'h104 + 32'(8*k), 32'hD000_0001 + 32'(2*k), SW);
            applyStimulus();
            checkOutput($sformatf("fill_free%0d", k), 32'(sqFree), 32'(6 - 2*k));
        end
        checkOutput("full_mvalid", 32'(memValid), 32'd0);
        checkFwd("full_fwd", 32'h104, 6'd20, 4'hF, 32'hD000_0001);
        checkFwd("full_older_ld", 32'h11C, 6'd9, 4'h0, 32'h0);

        retireLane(0, 6'd3);
        retireLane(1, 6'd4);
        memReady = 1'b1;
        applyStimulus();
        checkOutput("drain0_valid", 32'(memValid), 32'd1);
        checkOutput("drain0_addr", memAddr, 32'h100);
        checkOutput("drain0_data", memData, 32'hD000_0000);
        applyStimulus();
        checkOutput("drain1_valid", 32'(memValid), 32'd1);
        checkOutput("drain1_addr", memAddr, 32'h104);
        checkOutput("drain1_free", 32'(sqFree), 32'd1);
        applyStimulus();
        checkOutput("drain2_valid", 32'(memValid), 32'd0);
        checkOutput("drain2_free", 32'(sqFree), 32'd2);

        memReady = 1'b0;
        retireLane(0, 6'd5);
        applyStimulus();
        checkOutput("stall_func3", 32'(memFunc3), 32'(SW));
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput($sformatf("stall%0d_valid", k), 32'(memValid), 32'd1);
            checkOutput($sformatf("stall%0d_addr", k), memAddr, 32'h108);
            checkOutput($sformatf("stall%0d_data", k), memData, 32'hD000_0002);
            checkOutput($sformatf("stall%0d_free", k), 32'(sqFree), 32'd2);
        end
        memReady = 1'b1;
        applyStimulus();
        checkOutput("unstall_valid", 32'(memValid), 32'd0);
        checkOutput("unstall_free", 32'(sqFree), 32'd3);
        memReady = 1'b0;

        // ---------------- byte-merged forwarding ----------------
        doReset();
        enqLane(0, 6'd1, 32'h1000, 32'hAABB_CCDD, SW);
        enqLane(1, 6'd2, 32'h1002, 32'h1234_5611, SB);
        applyStimulus();
        checkOutput("fwd_free", 32'(sqFree), 32'd6);
        checkFwd("fwd_rob5", 32'h1000, 6'd5, 4'hF, 32'hAA11_CCDD);
        checkFwd("fwd_rob2", 32'h1000, 6'd2, 4'hF, 32'hAABB_CCDD);
        checkFwd("fwd_rob1", 32'h1000, 6'd1, 4'h0, 32'h0);
        checkFwd("fwd_offs3", 32'h1003, 6'd5, 4'hF, 32'hAA11_CCDD);

        enqLane(1, 6'd3, 32'h1002, 32'hFFFF_7788, SH);
        applyStimulus();
        checkOutput("fwd_lane1_free", 32'(sqFree), 32'd5);
        checkFwd("fwd_sh_rob5", 32'h1000, 6'd5, 4'hF, 32'h7788_CCDD);
        checkFwd("fwd_sh_rob3", 32'h1000, 6'd3, 4'hF, 32'hAA11_CCDD);

        enqLane(0, 6'd4, 32'h2001, 32'h0000_005A, SB);
        applyStimulus();
        checkFwd("fwd_sb_part", 32'h2000, 6'd5, 4'b0010, 32'h0000_5A00);
        checkFwd("fwd_miss", 32'h1004, 6'd5, 4'h0, 32'h0);

        // ---------------- flush with dropped enqueue, flush with dequeue ----------------
        doReset();
        for (int k = 0; k < 3; k++) begin
            enqLane(0, 6'(10 + 2*k), 32'h2000 + 32'(8*k), 32'h0000_00FA + 32'(2*k), SW);
            enqLane(1, 6'(11 + 2*k), 32'h2004 + 32'(8*k), 32'h0000_00FB + 32'(2*k), SW);
            applyStimulus();
        end
        checkOutput("fl_fill_free", 32'(sqFree), 32'd2);
        retireLane(0, 6'd10);
        retireLane(1, 6'd11);
        applyStimulus();
        checkOutput("fl_mvalid", 32'(memValid), 32'd1);

        flushValid = 1'b1;
        flushRobid = 6'd12;
        enqLane(0, 6'd16, 32'h3000, 32'h33, SW);
        applyStimulus();
        checkOutput("fl_free", 32'(sqFree), 32'd5);
        checkOutput("fl_head_addr", memAddr, 32'h2000);
        checkFwd("fl_rob13_gone", 32'h200C, 6'd30, 4'h0, 32'h0);
        checkFwd("fl_rob12_kept", 32'h2008, 6'd30, 4'hF, 32'h0000_00FC);
        checkFwd("fl_enq_dropped", 32'h3000, 6'd30, 4'h0, 32'h0);

        enqLane(0, 6'd13, 32'h2100, 32'h0000_1234, SW);
        applyStimulus();
        checkOutput("fl_reenq_free", 32'(sqFree), 32'd4);
        checkFwd("fl_reenq_fwd", 32'h2100, 6'd30, 4'hF, 32'h0000_1234);

        memReady   = 1'b1;
        flushValid = 1'b1;
        flushRobid = 6'd12;
        applyStimulus();
        memReady = 1'b0;
        checkOutput("fldq_free", 32'(sqFree), 32'd6);
        checkOutput("fldq_addr", memAddr, 32'h2004);
        checkOutput("fldq_valid", 32'(memValid), 32'd1);
        checkFwd("fldq_gone", 32'h2100, 6'd30, 4'h0, 32'h0);

        // ---------------- robid and pointer wrap-around ----------------
        doReset();
        for (int k = 0; k < 3; k++) begin
            enqLane(0, 6'(1 + 2*k), 32'h4000 + 32'(8*k), 32'h0, SW);
            enqLane(1, 6'(2 + 2*k), 32'h4004 + 32'(8*k), 32'h0, SW);
            applyStimulus();
        end
        for (int k = 0; k < 3; k++) begin
            retireLane(0, 6'(1 + 2*k));
            retireLane(1, 6'(2 + 2*k));
            applyStimulus();
        end
        memReady = 1'b1;
        for (int k = 0; k < 6; k++) applyStimulus();
        memReady = 1'b0;
        checkOutput("wr_empty_free", 32'(sqFree), 32'd8);
        checkOutput("wr_empty_valid", 32'(memValid), 32'd0);

        enqLane(0, 6'h1C, 32'h5000, 32'hE000_001C, SW);
        enqLane(1, 6'h1D, 32'h5004, 32'hE000_001D, SW);
        applyStimulus();
        checkOutput("wr_enq0_free", 32'(sqFree), 32'd6);
        enqLane(0, 6'h1E, 32'h5008, 32'hE000_001E, SW);
        enqLane(1, 6'h22, 32'h500C, 32'hE000_0022, SW);
        applyStimulus();
        checkOutput("wr_enq1_free", 32'(sqFree), 32'd4);
        checkFwd("wr_pre_fwd", 32'h500C, 6'h23, 4'hF, 32'hE000_0022);

        flushValid = 1'b1;
        flushRobid = 6'h1E;
        applyStimulus();
        checkOutput("wr_fl_free", 32'(sqFree), 32'd5);
        checkFwd("wr_fl_gone", 32'h500C, 6'h23, 4'h0, 32'h0);
        checkFwd("wr_fl_kept", 32'h5008, 6'h23, 4'hF, 32'hE000_001E);

        retireLane(0, 6'h1C);
        retireLane(1, 6'h1D);
        applyStimulus();
        retireLane(1, 6'h1E);
        applyStimulus();
        checkOutput("wr_dr0_addr", memAddr, 32'h5000);
        memReady = 1'b1;
        applyStimulus();
        checkOutput("wr_dr1_addr", memAddr, 32'h5004);
        applyStimulus();
        checkOutput("wr_dr2_addr", memAddr, 32'h5008);
        checkOutput("wr_dr2_valid", 32'(memValid), 32'd1);
        applyStimulus();
        memReady = 1'b0;
        checkOutput("wr_dr_done_valid", 32'(memValid), 32'd0);
        checkOutput("wr_dr_done_free", 32'(sqFree), 32'd8);

        enqLane(0, 6'h24, 32'h6000, 32'h0000_0066, SW);
        applyStimulus();
        checkOutput("wr_post_free", 32'(sqFree), 32'd7);
        checkFwd("wr_post_fwd", 32'h6000, 6'h25, 4'hF, 32'h0000_0066);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
